// File: rtl/debug_overlay_ctrl_if.sv
// debug_overlay_ctrl_if
//   Bundles the raster timing, button and overlay-strobe signals of the debug
//   overlay sequencer.
//   master : the video timing / board side (drives LINE_START, FRAME_START,
//            SHOW, BTN_RAW; observes the overlay strobes)
//   slave  : the sequencer itself
interface debug_overlay_ctrl_if;
  logic       line_start;   // 1-cycle pulse, start of raster line
  logic       frame_start;  // 1-cycle pulse, start of frame
  logic       show;         // overlay on/off level
  logic [3:0] btn_raw;      // raw buttons: next, prev, up, down
  logic       enable;       // vertical window active
  logic       newline;      // first column of a windowed line
  logic       pixel_mask;   // inside the overlay rectangle
  logic       button_en;    // once-per-frame event strobe
  logic [1:0] tool_b;       // {prev,next}
  logic [1:0] probe_b;      // {down,up}

  modport master (
    output line_start, frame_start, show, btn_raw,
    input  enable, newline, pixel_mask, button_en, tool_b, probe_b
  );

  modport slave (
    input  line_start, frame_start, show, btn_raw,
    output enable, newline, pixel_mask, button_en, tool_b, probe_b
  );
endinterface

// File: rtl/debug_overlay_ctrl.sv
// debug_overlay_ctrl
//   Debug overlay sequencer. Tracks the raster position from the line/frame
//   pulses, produces the overlay window strobes, debounces the four debug
//   buttons in units of frames and hands accepted presses to the overlay
//   renderer once per frame.
//   Ports:
//     clk   : pixel clock
//     reset : synchronous, active-high
//     bus   : debug_overlay_ctrl_if.slave (timing/button inputs, strobes out)

// Per-button debounce lane: two-flop synchronizer plus a frame-counting
// stability filter. rise pulses in the cycle the accepted level goes 0->1.
module debug_overlay_btn_lane #(
  parameter int unsigned DEBOUNCE_FRAMES = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  input  logic frame_start,
  output logic rise
);
  localparam logic [3:0] CNT_LAST = 4'(DEBOUNCE_FRAMES - 1);

  logic       sync1_q, sync1_d;
  logic       sync2_q, sync2_d;
  logic       acc_q, acc_d;
  logic [3:0] cnt_q, cnt_d;

  always_comb begin
    sync1_d = btn_raw;
    sync2_d = sync1_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    rise    = 1'b0;
    // Counter only runs while the synced level disagrees with the accepted
    // one; any bounce back to the accepted level restarts the count.
    if (sync2_q == acc_q) begin
      cnt_d = '0;
    end else if (frame_start) begin
      if (cnt_q == CNT_LAST) begin
        acc_d = sync2_q;
        cnt_d = '0;
        rise  = sync2_q;
      end else begin
        cnt_d = cnt_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      acc_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
    end
  end
endmodule

module debug_overlay_ctrl #(
  parameter int unsigned X_START         = 64,
  parameter int unsigned Y_START         = 16,
  parameter int unsigned WIDTH           = 320,
  parameter int unsigned HEIGHT          = 20,
  parameter int unsigned DEBOUNCE_FRAMES = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  debug_overlay_ctrl_if.slave  bus
);
  localparam int unsigned NUM_BTN = 4;
  localparam logic [10:0] H_MAX = 11'h7FF;
  localparam logic [9:0]  V_MAX = 10'h3FF;
  // Window bounds carried one bit wider than the counters so X+WIDTH and
  // Y+HEIGHT cannot wrap.
  localparam logic [11:0] X_LO = 12'(X_START);
  localparam logic [11:0] X_HI = 12'(X_START + WIDTH);
  localparam logic [10:0] Y_LO = 11'(Y_START);
  localparam logic [10:0] Y_HI = 11'(Y_START + HEIGHT);

  logic [10:0] h_q, h_d;
  logic [9:0]  v_q, v_d;
  logic        show_q, show_d;
  logic        enable_q, enable_d;
  logic        newline_q, newline_d;
  logic        pixel_mask_q, pixel_mask_d;
  logic        button_en_q, button_en_d;
  logic [1:0]  tool_q, tool_d;
  logic [1:0]  probe_q, probe_d;
  logic [NUM_BTN-1:0] pend_q, pend_d;

  logic [NUM_BTN-1:0] btn_raw;
  logic [NUM_BTN-1:0] rise;
  logic               in_v;
  logic               deliver;

  assign btn_raw = bus.btn_raw;

  debug_overlay_btn_lane #(
    .DEBOUNCE_FRAMES (DEBOUNCE_FRAMES)
  ) u_lane [NUM_BTN-1:0] (
    .clk         (clk),
    .reset       (reset),
    .btn_raw     (btn_raw),
    .frame_start (bus.frame_start),
    .rise        (rise)
  );

  // Raster position and frame-latched overlay switch.
  always_comb begin
    h_d = bus.line_start ? '0 : ((h_q == H_MAX) ? h_q : h_q + 11'd1);
    v_d = v_q;
    if (bus.frame_start)                     v_d = '0;
    else if (bus.line_start && v_q != V_MAX) v_d = v_q + 10'd1;
    show_d = bus.frame_start ? bus.show : show_q;
  end

  // Window strobes, registered from the current counter state.
  always_comb begin
    in_v         = show_q && ({1'b0, v_q} >= Y_LO) && ({1'b0, v_q} < Y_HI);
    enable_d     = in_v;
    newline_d    = in_v && ({1'b0, h_q} == X_LO);
    pixel_mask_d = in_v && ({1'b0, h_q} >= X_LO) && ({1'b0, h_q} < X_HI);
  end

  // Event delivery. Decided in the FRAME_START cycle from the incoming SHOW
  // level, so the strobe lands one cycle later together with the new show_q.
  // Presses accepted in that same cycle go into the fresh pending set and
  // wait for the next frame.
  always_comb begin
    deliver     = bus.frame_start && bus.show;
    button_en_d = deliver;
    tool_d      = 2'b00;
    probe_d     = 2'b00;
    pend_d      = pend_q | rise;
    if (deliver) begin
      // Opposing presses in one delivery cancel each other.
      tool_d  = (&pend_q[1:0]) ? 2'b00 : pend_q[1:0];
      probe_d = (&pend_q[3:2]) ? 2'b00 : pend_q[3:2];
      pend_d  = rise;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      h_q          <= '0;
      v_q          <= '0;
      show_q       <= 1'b0;
      enable_q     <= 1'b0;
      newline_q    <= 1'b0;
      pixel_mask_q <= 1'b0;
      button_en_q  <= 1'b0;
      tool_q       <= '0;
      probe_q      <= '0;
      pend_q       <= '0;
    end else begin
      h_q          <= h_d;
      v_q          <= v_d;
      show_q       <= show_d;
      enable_q     <= enable_d;
      newline_q    <= newline_d;
      pixel_mask_q <= pixel_mask_d;
      button_en_q  <= button_en_d;
      tool_q       <= tool_d;
      probe_q      <= probe_d;
      pend_q       <= pend_d;
    end
  end

  assign bus.enable     = enable_q;
  assign bus.newline    = newline_q;
  assign bus.pixel_mask = pixel_mask_q;
  assign bus.button_en  = button_en_q;
  assign bus.tool_b     = tool_q;
  assign bus.probe_b    = probe_q;
endmodule

// File: tb/tb_debug_overlay_ctrl.sv
// tb_debug_overlay_ctrl
//   Directed raster/button scenarios on a shrunken raster (24-cycle lines,
//   10 lines per frame) so many frames fit in a short run. A behavioural
//   model predicts every output each cycle; frame-level literal counts pin
//   the model.
module tb_debug_overlay_ctrl;
  localparam int X0 = 6, Y0 = 3, W = 12, H = 4, DB = 3;
  localparam int LINE = 24, LINES = 10;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  debug_overlay_ctrl_if bus();

  debug_overlay_ctrl #(
    .X_START(X0), .Y_START(Y0), .WIDTH(W), .HEIGHT(H), .DEBOUNCE_FRAMES(DB)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int total = 0, bad = 0;

  // model state
  int       m_h, m_v;
  bit       m_show;
  bit [3:0] m_s1, m_s2, m_acc, m_pend;
  int       m_cnt [4];
  bit       e_en, e_nl, e_pm, e_ben;
  bit [1:0] e_tool, e_probe;

  // observation
  int         en_cnt = 0, nl_cnt = 0, pm_cnt = 0, pos = 0, nl_pos = -1;
  logic [3:0] ben_log [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] outs();
    return {bus.enable, bus.newline, bus.pixel_mask, bus.button_en, bus.tool_b, bus.probe_b};
  endfunction

  // Predicts the outputs for the coming cycle from the inputs sampled at this edge.
  task automatic model_step();
    bit fs, ls, sh;
    bit [3:0] nw;
    fs = bus.frame_start; ls = bus.line_start; sh = bus.show;
    if (reset) begin
      m_h = 0; m_v = 0; m_show = 0; m_s1 = 0; m_s2 = 0; m_acc = 0; m_pend = 0;
      foreach (m_cnt[i]) m_cnt[i] = 0;
      {e_en, e_nl, e_pm, e_ben, e_tool, e_probe} = '0;
      return;
    end
    e_en = m_show && m_v >= Y0 && m_v < Y0 + H;
    e_nl = e_en && m_h == X0;
    e_pm = e_en && m_h >= X0 && m_h < X0 + W;
    nw = '0;
    for (int b = 0; b < 4; b++) begin
      if (m_s2[b] == m_acc[b]) m_cnt[b] = 0;
      else if (fs) begin
        m_cnt[b]++;
        if (m_cnt[b] == DB) begin
          m_acc[b] = m_s2[b];
          m_cnt[b] = 0;
          nw[b] = m_acc[b];
        end
      end
    end
    e_ben = fs && sh;
    if (e_ben) begin
      e_tool  = (m_pend[1:0] == 2'b11) ? 2'b00 : m_pend[1:0];
      e_probe = (m_pend[3:2] == 2'b11) ? 2'b00 : m_pend[3:2];
      m_pend  = nw;
    end else begin
      e_tool = 2'b00; e_probe = 2'b00;
      m_pend = m_pend | nw;
    end
    m_s2 = m_s1; m_s1 = bus.btn_raw;
    m_h = ls ? 0 : (m_h < 2047 ? m_h + 1 : 2047);
    if (fs) m_v = 0;
    else if (ls && m_v < 1023) m_v++;
    if (fs) m_show = sh;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    pos++;
    check($sformatf("cycle_pos%0d", pos), outs(), {e_en, e_nl, e_pm, e_ben, e_tool, e_probe});
    if (bus.enable)     en_cnt++;
    if (bus.pixel_mask) pm_cnt++;
    if (bus.newline) begin nl_cnt++; nl_pos = pos; end
    if (bus.button_en)  ben_log.push_back({bus.probe_b, bus.tool_b});
  endtask

  task automatic run_line(input bit fs);
    bus.line_start = 1'b1; bus.frame_start = fs; pos = 0;
    tick();
    bus.line_start = 1'b0; bus.frame_start = 1'b0;
    repeat (LINE - 1) tick();
  endtask

  // Lines [first,last) of a frame; line 0 carries FRAME_START.
  task automatic run_lines(input int first, input int last);
    for (int l = first; l < last; l++) run_line(l == 0);
  endtask

  task automatic run_frames(input int n);
    repeat (n) run_lines(0, LINES);
  endtask

  // Press mid-frame, hold across nfs FRAME_STARTs, release mid-frame, then
  // run 'after' more frames. base = log index of the first strobe after the press.
  task automatic press_hold(input logic [3:0] b, input int nfs, input int after, output int base);
    run_lines(0, 5);
    bus.btn_raw = b;
    base = ben_log.size();
    run_lines(5, LINES);
    run_frames(nfs - 1);
    run_lines(0, 5);
    bus.btn_raw = 4'b0;
    run_lines(5, LINES);
    run_frames(after);
  endtask

  function automatic int nz_from(input int base);
    int n = 0;
    for (int i = base; i < ben_log.size(); i++) if (ben_log[i] != 4'b0) n++;
    return n;
  endfunction

  initial begin
    int b0, b1, b2, b3, e0, n0, p0, l0;
    reset = 1'b1;
    bus.line_start = 1'b0; bus.frame_start = 1'b0; bus.show = 1'b0; bus.btn_raw = 4'b0;
    tick();
    check("reset_outputs", outs(), 8'h00);
    tick(); tick();
    reset = 1'b0; bus.show = 1'b1;

    // full frame, overlay on
    e0 = en_cnt; n0 = nl_cnt; p0 = pm_cnt; l0 = ben_log.size();
    run_frames(1);
    check("frame_enable_cycles", en_cnt - e0, 4 * LINE);
    check("frame_newlines", nl_cnt - n0, 4);
    check("frame_mask_cycles", pm_cnt - p0, 4 * W);
    check("newline_pos", nl_pos, X0 + 2);
    check("frame_button_en", ben_log.size() - l0, 1);

    // SHOW drops mid-frame: this frame intact, next frame dark
    e0 = en_cnt;
    run_lines(0, 2);
    bus.show = 1'b0;
    run_lines(2, LINES);
    check("show_off_cur_frame", en_cnt - e0, 4 * LINE);
    e0 = en_cnt; l0 = ben_log.size();
    run_frames(1);
    check("show_off_next_enable", en_cnt - e0, 0);
    check("show_off_next_ben", ben_log.size() - l0, 0);
    bus.show = 1'b1;
    e0 = en_cnt;
    run_frames(1);
    check("show_on_again", en_cnt - e0, 4 * LINE);

    // tool next held for 5 frames
    press_hold(4'b0001, 5, 3, b0);
    check("btn0_log_len", ben_log.size() - b0, 8);
    check("btn0_4th_event", ben_log[b0 + 3], 4'b0001);
    check("btn0_single_event", nz_from(b0), 1);

    // probe up glitch across 2 frames
    press_hold(4'b0100, 2, 3, b1);
    check("glitch_log_len", ben_log.size() - b1, 5);
    check("glitch_no_event", nz_from(b1), 0);

    // up+down accepted together cancel
    press_hold(4'b1100, 4, 3, b2);
    check("pair_log_len", ben_log.size() - b2, 7);
    check("pair_4th_zero", ben_log[b2 + 3], 4'b0000);
    check("pair_no_event", nz_from(b2), 0);

    // tool prev + probe up together (different pairs) both delivered
    press_hold(4'b0110, 5, 3, b3);
    check("combo_4th_event", ben_log[b3 + 3], 4'b0110);
    check("combo_single_event", nz_from(b3), 1);

    // one-cycle reset inside a windowed line
    run_lines(0, 4);
    bus.line_start = 1'b1; pos = 0;
    tick();
    bus.line_start = 1'b0;
    repeat (9) tick();
    check("mask_before_reset", bus.pixel_mask, 1'b1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("reset_mid_line", outs(), 8'h00);
    e0 = en_cnt;
    repeat (LINE - 11) tick();
    run_lines(5, LINES);
    check("enable_after_reset", en_cnt - e0, 0);
    e0 = en_cnt;
    run_frames(1);
    check("enable_next_frame", en_cnt - e0, 4 * LINE);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
